// File: rtl/tt_vp_pkg.sv
// Shared types and packed-vector layout helpers for the tt_vector_player slice.
// Vector layout, MSB first: last, ui, uio, exp, mask.
package tt_vp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int OFF_MASK = 0;

  function automatic int off_exp(input int out_w);
    return out_w;
  endfunction

  function automatic int off_uio(input int out_w);
    return 2 * out_w;
  endfunction

  function automatic int off_ui(input int in_w, input int out_w);
    return 2 * out_w + in_w;
  endfunction

  function automatic int off_last(input int in_w, input int out_w);
    return 2 * out_w + 2 * in_w;
  endfunction

  function automatic int vec_width(input int in_w, input int out_w);
    return 2 * in_w + 2 * out_w + 1;
  endfunction

endpackage

// File: rtl/tt_vp_delay.sv
// LAT-stage shift register carrying expected-value metadata alongside a valid bit.
// Flush drops all in-flight entries without touching the data stages.
module tt_vp_delay
  import tt_vp_pkg::*;
#(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld_q;
  logic [W-1:0]   dat_q [LAT];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/tt_vector_player.sv
// Pin-level vector replay and masked-compare engine for the tt_um_cpu_top wrapper.
// Drives one vector per clock and checks dut_uo SAMPLE_LAT cycles later.
module tt_vector_player
  import tt_vp_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int DEPTH      = 64,
  parameter int RST_CYCLES = 4,
  parameter int SAMPLE_LAT = 1,
  parameter int ERR_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [$clog2(DEPTH)-1:0]            wr_addr,
  input  logic [vec_width(IN_W, OUT_W)-1:0]   wr_data,
  input  logic                                start,
  input  logic                                loop_en,
  input  logic                                abort,
  input  logic [OUT_W-1:0]                    dut_uo,
  output logic [IN_W-1:0]                     dut_ui,
  output logic [IN_W-1:0]                     dut_uio,
  output logic                                dut_rst_n,
  output logic                                dut_ena,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [ERR_W-1:0]                    err_cnt,
  output logic [$clog2(DEPTH)-1:0]            fail_idx,
  output logic [7:0]                          pass_cnt
);

  localparam int AW       = $clog2(DEPTH);
  localparam int VW       = vec_width(IN_W, OUT_W);
  localparam int OFF_EXP  = off_exp(OUT_W);
  localparam int OFF_UIO  = off_uio(OUT_W);
  localparam int OFF_UI   = off_ui(IN_W, OUT_W);
  localparam int OFF_LAST = off_last(IN_W, OUT_W);
  localparam int DW       = 2 * OUT_W + AW;
  localparam int RCW      = $clog2(RST_CYCLES + 1);
  localparam int DCW      = $clog2(SAMPLE_LAT + 1);

  logic [VW-1:0]    mem_q [DEPTH];
  state_e           state_q;
  logic [RCW-1:0]   rcnt_q;
  logic [DCW-1:0]   dcnt_q;
  logic [AW-1:0]    addr_q;
  logic             loop_q;
  logic [IN_W-1:0]  ui_q;
  logic [IN_W-1:0]  uio_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [AW-1:0]    fail_q;
  logic [7:0]       passcnt_q;

  logic [AW-1:0]    addr_nx;
  logic             cur_last;
  logic [DW-1:0]    push_data;
  logic             push_valid;
  logic             chk_valid;
  logic [DW-1:0]    chk_data;
  logic [OUT_W-1:0] chk_exp;
  logic [OUT_W-1:0] chk_mask;
  logic [AW-1:0]    chk_idx;
  logic             mismatch;

  // Register file: writes only land while no replay is in progress.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !abort && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign addr_nx    = addr_q + AW'(1);
  assign cur_last   = mem_q[addr_q][OFF_LAST];
  assign push_valid = (state_q == ST_RUN);
  assign push_data  = {mem_q[addr_q][OFF_EXP +: OUT_W], mem_q[addr_q][OFF_MASK +: OUT_W], addr_q};

  tt_vp_delay #(
    .LAT (SAMPLE_LAT),
    .W   (DW)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (push_valid),
    .in_data   (push_data),
    .out_valid (chk_valid),
    .out_data  (chk_data)
  );

  assign chk_exp  = chk_data[DW-1 -: OUT_W];
  assign chk_mask = chk_data[AW +: OUT_W];
  assign chk_idx  = chk_data[AW-1:0];
  assign mismatch = chk_valid && (state_q == ST_RUN || state_q == ST_DRAIN) &&
                    (|((dut_uo ^ chk_exp) & chk_mask));
  assign err_d    = (err_q == '1) ? err_q : err_q + ERR_W'(1);

  // The vector currently on the pins is entry[addr_q]; the next one is loaded each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      dcnt_q    <= '0;
      addr_q    <= '0;
      loop_q    <= 1'b0;
      ui_q      <= '0;
      uio_q     <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      passcnt_q <= '0;
    end else begin
      if (mismatch) begin
        err_q <= err_d;
        if (err_q == '0) begin
          fail_q <= chk_idx;
        end
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RESET;
            rcnt_q    <= '0;
            loop_q    <= loop_en;
            ui_q      <= '0;
            uio_q     <= '0;
            err_q     <= '0;
            fail_q    <= '0;
            passcnt_q <= '0;
          end
        end
        ST_RESET: begin
          if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            ui_q    <= mem_q[0][OFF_UI +: IN_W];
            uio_q   <= mem_q[0][OFF_UIO +: IN_W];
          end else begin
            rcnt_q <= rcnt_q + RCW'(1);
          end
        end
        ST_RUN: begin
          if (cur_last || addr_q == AW'(DEPTH - 1)) begin
            if (loop_q) begin
              addr_q    <= '0;
              ui_q      <= mem_q[0][OFF_UI +: IN_W];
              uio_q     <= mem_q[0][OFF_UIO +: IN_W];
              passcnt_q <= passcnt_q + 8'd1;
            end else begin
              state_q <= ST_DRAIN;
              dcnt_q  <= '0;
            end
          end else begin
            addr_q <= addr_nx;
            ui_q   <= mem_q[addr_nx][OFF_UI +: IN_W];
            uio_q  <= mem_q[addr_nx][OFF_UIO +: IN_W];
          end
        end
        ST_DRAIN: begin
          if (dcnt_q == DCW'(SAMPLE_LAT - 1)) begin
            state_q <= ST_DONE;
          end else begin
            dcnt_q <= dcnt_q + DCW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_ui    = ui_q;
  assign dut_uio   = uio_q;
  assign dut_rst_n = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
  assign dut_ena   = (state_q != ST_IDLE);
  assign busy      = (state_q == ST_RESET) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (err_q == '0);
  assign err_cnt   = err_q;
  assign fail_idx  = fail_q;
  assign pass_cnt  = passcnt_q;

endmodule

// File: doc/tt_vector_player.md
# tt_vector_player

Parametrised, synthesizable pin-level stimulus/check engine for the `tt_um_cpu_top` bit-serial CPU wrapper. It holds a writable vector memory, drives the dedicated and bidirectional input pins of the design under test (DUT) one vector per clock, and compares the DUT outputs against masked expected values. It keeps a saturating mismatch count and the first failing index. It generalises the fixed-width, hand-driven bench harness: pin widths, vector depth, sample latency and loop mode are configurable, and pass/fail is decided in hardware.

## Interface
- `IN_W`, default 8: width of `dut_ui` and `dut_uio`.
- `OUT_W`, default 8: width of the checked DUT output `dut_uo`.
- `DEPTH`, default 64: number of vector entries; power of two, at least 2.
- `RST_CYCLES`, default 4: number of cycles DUT reset is held before the first vector; at least 1.
- `SAMPLE_LAT`, default 1: cycles from a vector appearing on `dut_ui` to sampling its `dut_uo`; range 1 to 4.
- `ERR_W`, default 8: width of the mismatch counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `wr_en` in 1: vector write strobe; honoured in IDLE and DONE only.
- `wr_addr` in log2(DEPTH): entry index to write.
- `wr_data` in 2*IN_W+2*OUT_W+1: packed vector, MSB first: `last`, `ui`, `uio`, `exp`, `mask`.
- `start` in 1: level; sampled in IDLE or DONE.
- `loop_en` in 1: sampled at start; when set, replay wraps after the `last` entry.
- `abort` in 1: return to IDLE; takes priority over every other input except `rst`.
- `dut_uo` in OUT_W: DUT dedicated outputs.
- `dut_ui` out IN_W: registered stimulus.
- `dut_uio` out IN_W: registered stimulus.
- `dut_rst_n` out 1: DUT reset, active-low.
- `dut_ena` out 1: DUT enable.
- `busy` out 1: state is RESET, RUN or DRAIN.
- `done` out 1: state is DONE.
- `pass` out 1: valid while `done` is high; high when `err_cnt` is 0.
- `err_cnt` out ERR_W: saturating mismatch count.
- `fail_idx` out log2(DEPTH): vector index of the first mismatch; 0 if there is none.
- `pass_cnt` out 8: completed loop passes; wraps modulo 256.

## Operation
- FSM states: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE to RESET on `start`. Entering RESET clears `err_cnt`, `fail_idx` and `pass_cnt`, and latches `loop_en`.
- RESET: `dut_rst_n`=0, `dut_ena`=1, `dut_ui`/`dut_uio`=0. Lasts RST_CYCLES cycles, then RUN with the read address at 0.
- RUN: each cycle registers entry[addr] onto `dut_ui`/`dut_uio` and pushes `{exp, mask, addr}` into a SAMPLE_LAT-deep delay line. The address increments each cycle.
- When the entry carries `last`=1 or the address is DEPTH-1:
  - with latched loop set: address wraps to 0, `pass_cnt` increments, and the state stays RUN;
  - otherwise: go to DRAIN.
- DRAIN: lasts SAMPLE_LAT cycles. Outputs hold the final vector while in-flight checks complete. Then DONE.
- DONE: `dut_ena` stays 1 and `dut_rst_n` stays 1. Results are held. `start` re-enters RESET.
- Check: at every delay-line output, a mismatch is `((dut_uo ^ exp) & mask) != 0`.
  - On a mismatch, `err_cnt` increments and saturates at 2^ERR_W-1.
  - On the first mismatch, `fail_idx` captures the delayed index.
  - Checks run only in RUN and DRAIN.
- `abort`: next state is IDLE from any state. Results are cleared and the delay line is flushed.
- Writes in RESET, RUN or DRAIN are dropped. A write and a `start` in the same cycle: the write lands first, and that entry is replayed.

## Timing
- Reset values: `dut_ui`=0, `dut_uio`=0, `dut_rst_n`=0, `dut_ena`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_idx`=0, `pass_cnt`=0; state IDLE. Vector memory contents are not reset.
- `start` is sampled at cycle S.
- RESET spans cycles S+1 to S+RST_CYCLES.
- Vector i is on `dut_ui` at cycle S+RST_CYCLES+1+i; its `dut_uo` is checked at that cycle plus SAMPLE_LAT.
- For N vectors in one-shot mode, `done` first rises at cycle S+RST_CYCLES+N+SAMPLE_LAT+1.
- `rst` or `abort` mid-run: outputs return to reset values the next cycle.
- Vector memory is synchronous-write and asynchronous-read (register file). Because of that, reads of a just-written entry return the new data.

## Structure
- Package `tt_vp_pkg`: state enum, field offset constants for the packed vector, and a function returning the vector width.
- Sub-module `tt_vp_delay`: parametrised SAMPLE_LAT-stage shift register with valid bit and flush.

## Test plan
- All-match, 4 vectors, RST_CYCLES=4, SAMPLE_LAT=1 → `done` at S+10, `pass`=1, `err_cnt`=0.
- Vector 2 expects 0xA5 with mask 0xFF, DUT returns 0xA4 → `err_cnt`=1, `fail_idx`=2, `pass`=0.
- Same as the previous case but mask 0xFE → `pass`=1.
- Forced mismatch every cycle, DEPTH=64, ERR_W=4 → `err_cnt` saturates at 15; `fail_idx`=0.
- `loop_en`=1, 3 vectors, run 10 cycles into RUN, then `abort` → `pass_cnt`=3 before the abort; next cycle state IDLE and all outputs at reset values.
- Write during RUN to entry 0 → ignored; the replayed value is unchanged. `rst` asserted mid-DRAIN → reset values the next cycle.
